// File: rtl/radar_scan_pkg.sv
// Shared types and constants for the vertical radar scan sequencer.
package radar_scan_pkg;

    localparam int CNT_W_DEF      = 16;
    localparam int START_HOLD_DEF = 4;

    typedef enum logic [5:0] {
        S_IDLE  = 6'b000001,
        S_ISSUE = 6'b000010,
        S_WAIT  = 6'b000100,
        S_TRIG  = 6'b001000,
        S_NEXT  = 6'b010000,
        S_DONE  = 6'b100000
    } state_t;

    function automatic logic [31:0] ms_to_cycles(input int unsigned ms, input int unsigned freq);
        longint unsigned prod;
        prod = 64'(ms) * 64'(freq) / 64'd1000;
        return prod[31:0];
    endfunction

endpackage

// File: rtl/radar_pedge_det.sv
// Registered rising-edge detector: pulse is high one cycle, one cycle after din rises.
module radar_pedge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic pulse
);

    logic prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev  <= 1'b0;
            pulse <= 1'b0;
        end else begin
            prev  <= din;
            pulse <= din & ~prev;
        end
    end

endmodule

// File: rtl/radar_v_scan_seq.sv
// Vertical scan sequencer: start edge -> motor start 2 cycles, event_done -> trig 1 cycle, trig -> next start 2 cycles.
// No backpressure; optional per-step watchdog built when RADAR_V_SCAN_WDOG_EN is defined.
module radar_v_scan_seq
    import radar_scan_pkg::*;
#(
    parameter int unsigned SYS_FREQ   = 100_000_000,
    parameter int          CNT_W      = CNT_W_DEF,
    parameter int          START_HOLD = START_HOLD_DEF,
    parameter int unsigned WDOG_MS    = 5000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             scan_start,
    input  logic             force_stop,
    input  logic [CNT_W-1:0] cfg_step_total,
    input  logic [CNT_W-1:0] cfg_sweeps,
    input  logic             cfg_dir_init,
    input  logic             v_event_done,
    output logic             vertical_start_o,
    output logic             v_sw_dir_o,
    output logic             radar_trig_o,
    output logic             busy,
    output logic             scan_done,
    output logic [CNT_W-1:0] step_idx,
    output logic [CNT_W-1:0] sweep_idx,
    output logic             err_timeout
);

    localparam int          HOLD_W   = $clog2(START_HOLD);
    localparam logic [31:0] WDOG_CYC = ms_to_cycles(WDOG_MS, SYS_FREQ);
    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t            state;
    logic              start_pulse;
    logic [HOLD_W-1:0] hold_cnt;
    logic [CNT_W-1:0]  sh_step_total;
    logic [CNT_W-1:0]  sh_sweeps;
`ifdef RADAR_V_SCAN_WDOG_EN
    logic [31:0]       wdog_cnt;
`endif

    radar_pedge_det u_start_edge (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (scan_start),
        .pulse (start_pulse)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= S_IDLE;
            vertical_start_o <= 1'b0;
            v_sw_dir_o       <= 1'b0;
            radar_trig_o     <= 1'b0;
            busy             <= 1'b0;
            scan_done        <= 1'b0;
            step_idx         <= '0;
            sweep_idx        <= '0;
            hold_cnt         <= '0;
            sh_step_total    <= '0;
            sh_sweeps        <= '0;
`ifdef RADAR_V_SCAN_WDOG_EN
            wdog_cnt         <= '0;
            err_timeout      <= 1'b0;
`endif
        end else begin
            radar_trig_o <= 1'b0;
            scan_done    <= 1'b0;
`ifdef RADAR_V_SCAN_WDOG_EN
            err_timeout  <= 1'b0;
`endif
            if (force_stop) begin
                state            <= S_IDLE;
                vertical_start_o <= 1'b0;
                busy             <= 1'b0;
                step_idx         <= '0;
                sweep_idx        <= '0;
                hold_cnt         <= '0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start_pulse) begin
                            sh_step_total <= cfg_step_total;
                            sh_sweeps     <= cfg_sweeps;
                            v_sw_dir_o    <= cfg_dir_init;
                            busy          <= 1'b1;
                            step_idx      <= '0;
                            sweep_idx     <= '0;
                            hold_cnt      <= '0;
                            // An empty scan still reports completion so software sees a clean handshake.
                            if (cfg_step_total == '0 || cfg_sweeps == '0) begin
                                state     <= S_DONE;
                                scan_done <= 1'b1;
                            end else begin
                                state            <= S_ISSUE;
                                vertical_start_o <= 1'b1;
                            end
                        end
                    end
                    S_ISSUE: begin
                        if (hold_cnt == HOLD_W'(START_HOLD - 1)) begin
                            vertical_start_o <= 1'b0;
                            state            <= S_WAIT;
`ifdef RADAR_V_SCAN_WDOG_EN
                            wdog_cnt         <= '0;
`endif
                        end else begin
                            hold_cnt <= hold_cnt + 1'b1;
                        end
                    end
                    S_WAIT: begin
                        if (v_event_done) begin
                            state        <= S_TRIG;
                            radar_trig_o <= 1'b1;
                        end
`ifdef RADAR_V_SCAN_WDOG_EN
                        else if (wdog_cnt == WDOG_CYC - 32'd1) begin
                            state       <= S_IDLE;
                            busy        <= 1'b0;
                            step_idx    <= '0;
                            sweep_idx   <= '0;
                            err_timeout <= 1'b1;
                        end else begin
                            wdog_cnt <= wdog_cnt + 32'd1;
                        end
`endif
                    end
                    S_TRIG: state <= S_NEXT;
                    S_NEXT: begin
                        hold_cnt <= '0;
                        if (step_idx == sh_step_total - ONE) begin
                            step_idx   <= '0;
                            sweep_idx  <= sweep_idx + ONE;
                            v_sw_dir_o <= ~v_sw_dir_o;
                            if (sweep_idx == sh_sweeps - ONE) begin
                                state     <= S_DONE;
                                scan_done <= 1'b1;
                            end else begin
                                state            <= S_ISSUE;
                                vertical_start_o <= 1'b1;
                            end
                        end else begin
                            step_idx         <= step_idx + ONE;
                            state            <= S_ISSUE;
                            vertical_start_o <= 1'b1;
                        end
                    end
                    S_DONE: begin
                        state     <= S_IDLE;
                        busy      <= 1'b0;
                        step_idx  <= '0;
                        sweep_idx <= '0;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

`ifndef RADAR_V_SCAN_WDOG_EN
    // Watchdog not built: output is constant low, WAIT has no time limit.
    assign err_timeout = (WDOG_CYC == 32'd0) && 1'b0;
`endif

endmodule

// File: tb/tb_radar_v_scan_seq.sv
// Bench for radar_v_scan_seq: plays the motor controller with random settle delays and checks against a sweep-order model.
module tb_radar_v_scan_seq;

    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             scan_start = 1'b0;
    logic             force_stop = 1'b0;
    logic [CNT_W-1:0] cfg_step_total = '0;
    logic [CNT_W-1:0] cfg_sweeps = '0;
    logic             cfg_dir_init = 1'b0;
    logic             v_event_done = 1'b0;
    logic             vertical_start_o, v_sw_dir_o, radar_trig_o, busy, scan_done, err_timeout;
    logic [CNT_W-1:0] step_idx, sweep_idx;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    radar_v_scan_seq #(
        .SYS_FREQ   (1_000_000),
        .CNT_W      (CNT_W),
        .START_HOLD (4),
        .WDOG_MS    (1)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .scan_start       (scan_start),
        .force_stop       (force_stop),
        .cfg_step_total   (cfg_step_total),
        .cfg_sweeps       (cfg_sweeps),
        .cfg_dir_init     (cfg_dir_init),
        .v_event_done     (v_event_done),
        .vertical_start_o (vertical_start_o),
        .v_sw_dir_o       (v_sw_dir_o),
        .radar_trig_o     (radar_trig_o),
        .busy             (busy),
        .scan_done        (scan_done),
        .step_idx         (step_idx),
        .sweep_idx        (sweep_idx),
        .err_timeout      (err_timeout)
    );

    // Scenario engine: drives one scan, acts as the motor controller, checks every observable event.
    task automatic run_scan(input int n, input int m, input bit dir, input int stop_after, input bit disturb);
        int exp_step[$];
        int exp_sweep[$];
        bit exp_dir[$];
        int exp_trigs, exp_starts;
        int trigs = 0, starts = 0, dones = 0, hold = 0, done_ctr = -1;
        int cyc = 0, trig_cyc = 0, done_cyc = -10, quiet = 0;
        bit prev_vs = 0, legit = 0, stopped = 0, stop_chk = 0, issue_dir = 0;
        bit nxt_done, nxt_stop, nxt_legit;
        for (int s = 0; s < m; s++)
            for (int k = 0; k < n; k++) begin
                exp_step.push_back(k);
                exp_sweep.push_back(s);
                exp_dir.push_back(dir ^ s[0]);
            end
        if (stop_after >= 0) begin
            exp_trigs  = stop_after;
            exp_starts = stop_after + 1;
        end else begin
            exp_trigs  = n * m;
            exp_starts = n * m;
        end
        cfg_step_total = CNT_W'(n);
        cfg_sweeps     = CNT_W'(m);
        cfg_dir_init   = dir;
        @(negedge clk);
        scan_start = 1'b1;
        while (cyc < 3000 && quiet < 12) begin
            @(negedge clk);
            cyc++;
            nxt_done = 0; nxt_stop = 0; nxt_legit = 0;
            if (stop_chk) begin
                stop_chk = 0;
                n_cmp++;
                if (busy !== 1'b0 || vertical_start_o !== 1'b0 || step_idx !== '0 || sweep_idx !== '0) begin
                    n_bad++;
                    $display("FAIL stop_state: busy=%0b start=%0b step=%0d sweep=%0d, required all 0",
                             busy, vertical_start_o, step_idx, sweep_idx);
                end
            end
            if (radar_trig_o || legit) begin
                n_cmp++;
                if (radar_trig_o !== legit) begin
                    n_bad++;
                    $display("FAIL trig_timing: cyc=%0d trig=%0b, required %0b", cyc, radar_trig_o, legit);
                end
            end
            if (radar_trig_o) begin
                n_cmp++;
                if (exp_step.size() == 0) begin
                    n_bad++;
                    $display("FAIL trig_extra: cyc=%0d unexpected radar_trig_o, required none", cyc);
                end else begin
                    if (step_idx !== CNT_W'(exp_step[0]) || sweep_idx !== CNT_W'(exp_sweep[0]) ||
                        v_sw_dir_o !== exp_dir[0] || issue_dir !== exp_dir[0]) begin
                        n_bad++;
                        $display("FAIL trig_ctx: step=%0d sweep=%0d dir=%0b issue_dir=%0b, required step=%0d sweep=%0d dir=%0b",
                                 step_idx, sweep_idx, v_sw_dir_o, issue_dir, exp_step[0], exp_sweep[0], exp_dir[0]);
                    end
                    void'(exp_step.pop_front());
                    void'(exp_sweep.pop_front());
                    void'(exp_dir.pop_front());
                end
                trigs++;
                trig_cyc = cyc;
            end
            if (vertical_start_o && !prev_vs) begin
                starts++;
                hold = 0;
                issue_dir = v_sw_dir_o;
                n_cmp++;
                if (cyc != ((starts == 1) ? 2 : trig_cyc + 2)) begin
                    n_bad++;
                    $display("FAIL start_latency: start #%0d at cyc %0d, required %0d",
                             starts, cyc, (starts == 1) ? 2 : trig_cyc + 2);
                end
            end
            if (vertical_start_o) hold++;
            if (!vertical_start_o && prev_vs) begin
                n_cmp++;
                if (hold != 4) begin
                    n_bad++;
                    $display("FAIL start_hold: held %0d cycles, required 4", hold);
                end
                if (!stopped && stop_after >= 0 && trigs == stop_after) begin
                    nxt_stop = 1; nxt_done = 1; stopped = 1; stop_chk = 1;
                end else begin
                    done_ctr = $urandom_range(4, 0);
                end
            end
            if (done_ctr == 0) begin
                nxt_done = 1; nxt_legit = 1; done_ctr = -1;
            end else if (done_ctr > 0) begin
                done_ctr--;
            end
            if (disturb && starts == 1 && vertical_start_o) begin
                if (hold == 2) begin
                    nxt_done = 1;
                    scan_start = 1'b0;
                    cfg_step_total = CNT_W'(7);
                end
                if (hold == 3) scan_start = 1'b1;
            end
            if (scan_done) begin
                dones++;
                done_cyc = cyc;
                n_cmp++;
                if (busy !== 1'b1 || trigs != exp_trigs || stopped) begin
                    n_bad++;
                    $display("FAIL done_state: busy=%0b trigs=%0d stopped=%0b, required busy=1 trigs=%0d stopped=0",
                             busy, trigs, stopped, exp_trigs);
                end
                if (n * m == 0) begin
                    n_cmp++;
                    if (cyc != 2) begin
                        n_bad++;
                        $display("FAIL done_latency: scan_done at cyc %0d, required 2", cyc);
                    end
                end
            end
            if (cyc == done_cyc + 1) begin
                n_cmp++;
                if (busy !== 1'b0) begin
                    n_bad++;
                    $display("FAIL busy_after_done: busy=%0b, required 0", busy);
                end
            end
            if (err_timeout) begin
                n_cmp++;
                n_bad++;
                $display("FAIL err_timeout: pulse at cyc %0d, required none", cyc);
            end
            if (!busy && (dones > 0 || stopped)) quiet++;
            prev_vs = vertical_start_o;
            v_event_done = nxt_done;
            force_stop   = nxt_stop;
            legit        = nxt_legit;
        end
        n_cmp++;
        if (quiet < 12) begin
            n_bad++;
            $display("FAIL scan_timeout: scan n=%0d m=%0d did not finish in %0d cycles", n, m, cyc);
        end
        n_cmp++;
        if (trigs != exp_trigs || starts != exp_starts || dones != (stopped ? 0 : 1)) begin
            n_bad++;
            $display("FAIL scan_counts: trigs=%0d starts=%0d dones=%0d, required trigs=%0d starts=%0d dones=%0d",
                     trigs, starts, dones, exp_trigs, exp_starts, stopped ? 0 : 1);
        end
        v_event_done = 1'b0;
        force_stop   = 1'b0;
        scan_start   = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({vertical_start_o, v_sw_dir_o, radar_trig_o, busy, scan_done, err_timeout, step_idx, sweep_idx} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: start=%0b dir=%0b trig=%0b busy=%0b done=%0b err=%0b step=%0d sweep=%0d, required all 0",
                     vertical_start_o, v_sw_dir_o, radar_trig_o, busy, scan_done, err_timeout, step_idx, sweep_idx);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0 || vertical_start_o !== 1'b0) begin
            n_bad++;
            $display("FAIL idle_after_reset: busy=%0b start=%0b, required 0 0", busy, vertical_start_o);
        end
    endtask

    task automatic test_basic();
        run_scan(3, 2, 1'b1, -1, 1'b0);
    endtask

    task automatic test_zero_cfg();
        run_scan(0, 5, 1'b0, -1, 1'b0);
        run_scan(2, 0, 1'b1, -1, 1'b0);
    endtask

    task automatic test_force_stop();
        run_scan(4, 1, 1'b0, 1, 1'b0);
    endtask

    task automatic test_ignored_inputs();
        run_scan(3, 2, 1'b0, -1, 1'b1);
    endtask

    task automatic test_random();
        for (int i = 0; i < 4; i++)
            run_scan($urandom_range(3, 1), $urandom_range(3, 1), 1'($urandom_range(1, 0)), -1, 1'b0);
    endtask

    task automatic test_async_reset();
        int i;
        cfg_step_total = CNT_W'(2);
        cfg_sweeps     = CNT_W'(2);
        cfg_dir_init   = 1'b1;
        @(negedge clk);
        scan_start = 1'b1;
        i = 0;
        while (i < 10 && vertical_start_o !== 1'b1) begin
            @(negedge clk);
            i++;
        end
        n_cmp++;
        if (vertical_start_o !== 1'b1) begin
            n_bad++;
            $display("FAIL async_setup: start=%0b after %0d cycles, required 1", vertical_start_o, i);
        end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({vertical_start_o, v_sw_dir_o, radar_trig_o, busy, scan_done, step_idx, sweep_idx} !== '0) begin
            n_bad++;
            $display("FAIL async_reset: start=%0b dir=%0b busy=%0b step=%0d sweep=%0d, required all 0",
                     vertical_start_o, v_sw_dir_o, busy, step_idx, sweep_idx);
        end
        scan_start = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

`ifdef RADAR_V_SCAN_WDOG_EN
    task automatic test_watchdog();
        int c;
        int i;
        cfg_step_total = CNT_W'(1);
        cfg_sweeps     = CNT_W'(1);
        cfg_dir_init   = 1'b0;
        @(negedge clk);
        scan_start = 1'b1;
        i = 0;
        while (i < 10 && vertical_start_o !== 1'b1) begin
            @(negedge clk);
            i++;
        end
        while (i < 20 && vertical_start_o !== 1'b0) begin
            @(negedge clk);
            i++;
        end
        c = 0;
        while (c < 1100 && err_timeout !== 1'b1) begin
            @(negedge clk);
            c++;
        end
        n_cmp++;
        if (c != 1000 || busy !== 1'b0 || scan_done !== 1'b0) begin
            n_bad++;
            $display("FAIL watchdog: err after %0d cycles busy=%0b done=%0b, required 1000 0 0", c, busy, scan_done);
        end
        scan_start = 1'b0;
        repeat (3) @(negedge clk);
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_zero_cfg();
        test_force_stop();
        test_ignored_inputs();
        test_random();
        test_async_reset();
`ifdef RADAR_V_SCAN_WDOG_EN
        test_watchdog();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: bench did not complete, compared=%0d mismatched=%0d", n_cmp, n_bad);
        $fatal(1, "timeout");
    end

endmodule
